// File: rtl/pipe_stage_elastic.sv
// Elastic DEPTH-stage pipeline register with valid/ready handshake, bubble
// collapsing, flush and start gating; ctrl is forced to zero in empty slots.
module pipe_stage_elastic #(
  parameter int DATA_W         = 32,
  parameter int CTRL_W         = 8,
  parameter int DEPTH          = 1,
  parameter bit ZERO_ON_BUBBLE = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [2:0]        count_o
);

  if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
    $error("pipe_stage_elastic: DEPTH must be in 1..4");
  end

  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  ready_c;
  logic [CTRL_W-1:0] ctrl_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  // A stage can load when it is empty or its occupant moves on this edge.
  always_comb begin
    logic rdy_next;
    rdy_next = out_ready_i;
    ready_c  = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      rdy_next   = ~valid_q[k] | rdy_next;
      ready_c[k] = rdy_next;
    end
  end

  // Flush drops the incoming item but keeps ready high so upstream never stalls.
  assign in_ready_o = rst_i & start_i & (flush_i | ready_c[0]);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic              src_valid;
      logic [CTRL_W-1:0] src_ctrl;
      logic [DATA_W-1:0] src_data;
      logic              valid_reg;
      logic [CTRL_W-1:0] ctrl_reg;
      logic [DATA_W-1:0] data_reg;

      if (gi == 0) begin : g_head
        assign src_valid = in_valid_i;
        assign src_ctrl  = ctrl_i;
        assign src_data  = data_i;
      end else begin : g_body
        assign src_valid = valid_q[gi-1];
        assign src_ctrl  = ctrl_q[gi-1];
        assign src_data  = data_q[gi-1];
      end

      always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
          valid_reg <= 1'b0;
          ctrl_reg  <= '0;
          data_reg  <= '0;
        end else if (!start_i) begin
          valid_reg <= 1'b0;
          ctrl_reg  <= '0;
          data_reg  <= '0;
        end else if (flush_i) begin
          valid_reg <= 1'b0;
          ctrl_reg  <= '0;
          if (ZERO_ON_BUBBLE) data_reg <= '0;
        end else if (ready_c[gi]) begin
          valid_reg <= src_valid;
          if (src_valid) begin
            ctrl_reg <= src_ctrl;
            data_reg <= src_data;
          end else begin
            ctrl_reg <= '0;
            if (ZERO_ON_BUBBLE) data_reg <= '0;
          end
        end
      end

      assign valid_q[gi] = valid_reg;
      assign ctrl_q[gi]  = ctrl_reg;
      assign data_q[gi]  = data_reg;
    end
  endgenerate

  always_comb begin
    logic [2:0] cnt;
    cnt = '0;
    for (int k = 0; k < DEPTH; k++) cnt = cnt + 3'(valid_q[k]);
    count_o = cnt;
  end

  assign out_valid_o = valid_q[DEPTH-1];
  assign ctrl_o      = ctrl_q[DEPTH-1];
  assign data_o      = data_q[DEPTH-1];

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Randomized + directed bench for pipe_stage_elastic: a slot-position model
// predicts occupancy/handshakes, a scoreboard queue checks delivered payloads.
module tb_pipe_stage_elastic;
  localparam int DEPTH  = 3;
  localparam int DATA_W = 32;
  localparam int CTRL_W = 8;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic              start_i = 1'b1;
  logic              flush_i = 1'b0;
  logic              in_valid_i = 1'b0;
  logic              in_ready_o;
  logic [CTRL_W-1:0] ctrl_i = '0;
  logic [DATA_W-1:0] data_i = '0;
  logic              out_valid_o;
  logic              out_ready_i = 1'b0;
  logic [CTRL_W-1:0] ctrl_o;
  logic [DATA_W-1:0] data_o;
  logic [2:0]        count_o;

  pipe_stage_elastic #(
    .DATA_W(DATA_W), .CTRL_W(CTRL_W), .DEPTH(DEPTH), .ZERO_ON_BUBBLE(1'b1)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .ctrl_i(ctrl_i),
    .data_i(data_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .ctrl_o(ctrl_o), .data_o(data_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;
  logic [CTRL_W+DATA_W-1:0] exp_q[$];  // payloads in flight, oldest first
  int pos_q[$];                        // slot index of each item, oldest first

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: an item leaves at the next edge when presented and accepted.
  always @(negedge clk_i) begin
    logic [CTRL_W+DATA_W-1:0] e;
    if (rst_i && start_i && !flush_i && out_valid_o && out_ready_i) begin
      chk("sb_has_item", 64'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("data_o", data_o, e[DATA_W-1:0]);
        chk("ctrl_o", ctrl_o, e[CTRL_W+DATA_W-1:DATA_W]);
        $display("deliver ctrl=%02h data=%08h t=%0t", ctrl_o, data_o, $time);
      end
    end
  end

  // Reference model: items occupy slots; each moves one slot forward if the
  // slot ahead is free after older items have moved; the oldest leaves from
  // the last slot when out_ready_i is high.
  always @(negedge clk_i) begin
    int  new_pos[$];
    int  lim;
    bit  m_valid;
    bit  deliver;
    #1;
    if (!rst_i) begin
      chk("rst_out_valid", out_valid_o, 0);
      chk("rst_count", count_o, 0);
      chk("rst_in_ready", in_ready_o, 0);
      chk("rst_ctrl", ctrl_o, 0);
      chk("rst_data", data_o, 0);
      pos_q.delete();
      exp_q.delete();
    end else begin
      m_valid = (pos_q.size() > 0) && (pos_q[0] == DEPTH - 1);
      chk("count_o", count_o, pos_q.size());
      chk("out_valid_o", out_valid_o, m_valid);
      if (!m_valid) begin
        chk("bubble_ctrl", ctrl_o, 0);
        chk("bubble_data", data_o, 0);
      end
      deliver = m_valid && out_ready_i;
      new_pos.delete();
      lim = DEPTH;
      for (int i = 0; i < pos_q.size(); i++) begin
        int p;
        int q;
        p = pos_q[i];
        if (i == 0 && deliver) continue;
        q = (p + 1 < lim) ? p + 1 : p;
        new_pos.push_back(q);
        lim = q;
      end
      chk("in_ready_o", in_ready_o, start_i && (flush_i || lim > 0));
      if (!start_i || flush_i) begin
        pos_q.delete();
        exp_q.delete();
      end else begin
        pos_q = new_pos;
        if (in_valid_i && lim > 0) begin
          pos_q.push_back(0);
          exp_q.push_back({ctrl_i, data_i});
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  // Present one item and hold it until accepted (bounded wait).
  task automatic send(input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    in_valid_i = 1'b1;
    ctrl_i = c;
    data_i = d;
    do begin
      @(negedge clk_i);
      acc = in_ready_o;
      @(posedge clk_i);
      #1;
      n++;
    end while (!acc && n < 50);
    chk("send_accepted", acc, 1);
    in_valid_i = 1'b0;
  endtask

  initial begin
    // Reset held with garbage on the input pins
    rst_i = 1'b0; start_i = 1'b1; out_ready_i = 1'b1;
    in_valid_i = 1'b1; data_i = 32'hDEADBEEF; ctrl_i = 8'hFF;
    repeat (3) cyc();
    chk("init_out_valid", out_valid_o, 0);
    chk("init_ctrl", ctrl_o, 0);
    chk("init_data", data_o, 0);
    chk("init_count", count_o, 0);
    chk("init_in_ready", in_ready_o, 0);
    rst_i = 1'b1; in_valid_i = 1'b0; data_i = '0; ctrl_i = '0;
    cyc();

    // Streaming at full rate
    out_ready_i = 1'b1;
    for (int i = 1; i <= 3; i++) send(8'h81, DATA_W'(i));
    repeat (DEPTH + 2) cyc();

    // Backpressure: fourth item waits until downstream opens
    out_ready_i = 1'b0;
    send(8'h0A, 32'hA); send(8'h0B, 32'hB); send(8'h0C, 32'hC);
    in_valid_i = 1'b1; ctrl_i = 8'h0D; data_i = 32'hD;
    cyc(); cyc();
    chk("bp_full_in_ready", in_ready_o, 0);
    chk("bp_full_count", count_o, 3);
    out_ready_i = 1'b1;
    #1;
    chk("bp_open_in_ready", in_ready_o, 1);
    cyc();
    in_valid_i = 1'b0;
    repeat (DEPTH + 2) cyc();

    // Bubble collapse
    out_ready_i = 1'b0;
    send(8'h01, 32'h10);
    cyc();
    send(8'h02, 32'h20);
    repeat (3) cyc();
    chk("collapse_count", count_o, 2);
    chk("collapse_valid", out_valid_o, 1);
    out_ready_i = 1'b1;
    repeat (DEPTH + 1) cyc();

    // Flush drops contents and the concurrent input
    out_ready_i = 1'b0;
    send(8'h31, 32'h31); send(8'h32, 32'h32);
    chk("pre_flush_count", count_o, 2);
    flush_i = 1'b1; in_valid_i = 1'b1; ctrl_i = 8'h55; data_i = 32'h55;
    cyc();
    flush_i = 1'b0; in_valid_i = 1'b0;
    chk("flush_count", count_o, 0);
    chk("flush_valid", out_valid_o, 0);
    chk("flush_ctrl", ctrl_o, 0);
    out_ready_i = 1'b1;
    repeat (DEPTH + 2) cyc();

    // Start gating
    start_i = 1'b0; in_valid_i = 1'b1; ctrl_i = 8'h66; data_i = 32'h66;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("nostart_in_ready", in_ready_o, 0);
      chk("nostart_count", count_o, 0);
    end
    start_i = 1'b1;
    send(8'h77, 32'h77);
    repeat (DEPTH + 2) cyc();

    // Asynchronous reset mid-cycle with a full pipeline
    out_ready_i = 1'b0;
    send(8'h41, 32'h41); send(8'h42, 32'h42); send(8'h43, 32'h43);
    chk("pre_rst_count", count_o, 3);
    @(posedge clk_i);
    #3;
    rst_i = 1'b0;
    #1;
    chk("async_rst_valid", out_valid_o, 0);
    chk("async_rst_count", count_o, 0);
    chk("async_rst_ctrl", ctrl_o, 0);
    chk("async_rst_data", data_o, 0);
    chk("async_rst_in_ready", in_ready_o, 0);
    cyc();
    rst_i = 1'b1;
    cyc();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      in_valid_i  = ($urandom_range(0, 9) < 7);
      out_ready_i = ($urandom_range(0, 9) < 6);
      flush_i     = ($urandom_range(0, 99) < 3);
      start_i     = !($urandom_range(0, 99) < 3);
      data_i      = $urandom;
      ctrl_i      = CTRL_W'($urandom);
      cyc();
    end
    flush_i = 1'b0; start_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b1;
    repeat (DEPTH + 2) cyc();
    chk("drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised successor to the fixed MEM/WB-style pipeline register.
- Provides a DEPTH-stage elastic pipeline with a valid/ready handshake, bubble collapsing, flush and start gating.
- Carries a separate control field that is forced to zero on bubbles, so write-enables never leak from empty slots.
- Sits between any two datapath stages (e.g. MEM->WB), replacing hand-written per-stage registers.

Parameters:
- DATA_W, 32, width of the data payload (ALU result, memory data, etc., concatenated by the caller).
- CTRL_W, 8, width of the control payload (RegWrite, MemtoReg, rd address, etc.).
- DEPTH, 1, number of register stages; legal range 1..4.
- ZERO_ON_BUBBLE, 1, 1: a stage's data is also cleared when it goes empty; 0: data is held and only ctrl is cleared.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  run enable; low = pipeline held empty.
- flush_i  in  1  synchronous flush of all stages.
- in_valid_i  in  1  upstream item present.
- in_ready_o  out  1  stage 0 can accept this cycle.
- ctrl_i  in  CTRL_W  upstream control payload.
- data_i  in  DATA_W  upstream data payload.
- out_valid_o  out  1  last stage holds an item.
- out_ready_i  in  1  downstream accepts.
- ctrl_o  out  CTRL_W  last-stage control; zero whenever out_valid_o=0.
- data_o  out  DATA_W  last-stage data.
- count_o  out  3  number of valid stages, 0..DEPTH.

Behaviour:
- Reset (rst_i=0, asynchronous): all stage valid bits, ctrl and data go to 0. Hence out_valid_o=0, ctrl_o=0, data_o=0, count_o=0. in_ready_o=0 while reset is asserted.
- Priority, highest first: reset > ~start_i > flush_i > normal operation.
- start_i=0: at each edge all valid/ctrl/data are cleared. in_ready_o=0 combinationally; no item is accepted or delivered.
- flush_i=1 (with start_i=1): at the edge all valid bits and ctrl are cleared (data too if ZERO_ON_BUBBLE=1). An in_valid_i in the same cycle is dropped; in_ready_o stays 1 so the upstream does not stall.
- Normal operation, stages k=0..DEPTH-1, last = DEPTH-1:
  - adv[last] = out_ready_i.
  - ready[k] = ~valid[k] | ready[k+1], with ready[DEPTH] = out_ready_i.
  - in_ready_o = ready[0].
  - Stage k loads stage k-1 (or the input, for k=0) when ready[k]=1.
  - The loaded valid bit is valid[k-1], or in_valid_i for k=0.
  - A loaded bubble clears ctrl (and data when ZERO_ON_BUBBLE=1).
  - When ready[k]=0 the stage holds all of its contents.
- The ready chain is combinational from out_ready_i to in_ready_o, a depth-DEPTH OR chain. valid/ctrl/data outputs are registered only.
- Latency: an accepted item appears at out_valid_o exactly DEPTH edges after acceptance if never back-pressured.
- Throughput: one item per cycle when out_ready_i=1.
- Bubble collapse: with out_ready_i=0, new items advance into empty downstream stages until all DEPTH stages are full. in_ready_o then drops to 0.
- Ordering: strictly FIFO; no item is duplicated or lost except by flush, start_i=0 or reset.
- count_o equals the popcount of the valid bits and is updated with the same edge.
- Simultaneous accept and deliver while full: out_ready_i=1 makes the whole chain ready, so the pipeline shifts and count_o is unchanged.
- Reset mid-operation: contents are discarded immediately. After reset release, the first edge with start_i=1 behaves as an empty pipeline.
- DEPTH outside 1..4: elaboration error.

Test Plan:
- Reset check: hold rst_i=0 with in_valid_i=1 and the data_i/ctrl_i pins at 0xDEADBEEF/0xFF -> out_valid_o=0, ctrl_o=0, data_o=0, count_o=0, in_ready_o=0. Then assert rst_i=0 asynchronously mid-cycle while the pipeline is full -> outputs clear before the next edge.
- Streaming, DEPTH=2, out_ready_i=1: push data 1,2,3 on consecutive cycles with ctrl=0x81 -> data_o=1,2,3 on cycles 2,3,4 after acceptance. ctrl_o=0x81 while valid and 0x00 on the following bubble. count_o peaks at 2.
- Backpressure, DEPTH=3, out_ready_i=0: push 0xA,0xB,0xC,0xD -> first three accepted, in_ready_o=0 on the 4th, count_o=3. Raise out_ready_i -> 0xD is accepted that same cycle and the output order is A,B,C,D.
- Bubble collapse, DEPTH=3: push 0x10, idle 1 cycle, push 0x20, with out_ready_i=0 throughout -> both reach adjacent tail stages and count_o=2. 0x10 is delivered first and 0x20 the next cycle once out_ready_i=1.
- Flush: pipeline holding 2 items, assert flush_i=1 with in_valid_i=1 (data 0x55) -> after the edge count_o=0, out_valid_o=0, ctrl_o=0, and 0x55 never appears.
- start_i=0 for 3 cycles with in_valid_i=1 -> in_ready_o=0 and count_o=0. Raise start_i -> the next item emerges with DEPTH latency.
